onewire_seq: RTL and testbench

Command-level sequencer for the 1-wire bus. It accepts RESET, WRITE_BYTE and READ_BYTE commands over a valid/ready handshake. It generates the open-drain slot timing and returns the read byte and the presence result. It sits between the host-side control logic and the top-level open-drain `port` pad: `port = bus_oe ? 1'b0 : 1'bz`, with an external pull-up.

---
 rtl/onewire_pkg.sv | 30 +++
 rtl/onewire_sync.sv | 22 ++
 rtl/onewire_seq.sv | 150 +++++++++++++++
 tb/tb_onewire_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-wire command sequencer.
// Holds op codes, FSM state codes and the default slot timing (clk cycles).
package onewire_pkg;

   localparam logic [1:0] OP_RESET = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RST_LOW  = 3'd1;
   localparam logic [2:0] ST_RST_WAIT = 3'd2;
   localparam logic [2:0] ST_SLOT     = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   localparam int DEF_T_RSTL = 480;
   localparam int DEF_T_RSTH = 480;
   localparam int DEF_T_MSP  = 70;
   localparam int DEF_T_SLOT = 70;
   localparam int DEF_T_LOW0 = 60;
   localparam int DEF_T_LOW1 = 6;
   localparam int DEF_T_RDS  = 15;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchronizer for the raw 1-wire line level.
// Resets to 1 so the idle (pulled-up) bus never looks like a slave pulling low.
module onewire_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/onewire_seq.sv
// 1-wire command sequencer: RESET / WRITE_BYTE / READ_BYTE over valid/ready,
// generating open-drain slot timing and returning read data and presence.
module onewire_seq
   import onewire_pkg::*;
#(
   parameter int T_RSTL = DEF_T_RSTL,
   parameter int T_RSTH = DEF_T_RSTH,
   parameter int T_MSP  = DEF_T_MSP,
   parameter int T_SLOT = DEF_T_SLOT,
   parameter int T_LOW0 = DEF_T_LOW0,
   parameter int T_LOW1 = DEF_T_LOW1,
   parameter int T_RDS  = DEF_T_RDS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_presence,
   output logic       busy,
   output logic       bus_oe,
   input  logic       bus_in
);

   localparam int CW = $clog2(max3(T_RSTL, T_RSTH, T_SLOT) + 1);

   localparam logic [CW-1:0] RSTL_END = CW'(T_RSTL - 1);
   localparam logic [CW-1:0] RSTH_END = CW'(T_RSTH - 1);
   localparam logic [CW-1:0] SLOT_END = CW'(T_SLOT - 1);
   localparam logic [CW-1:0] MSP_AT   = CW'(T_MSP);
   localparam logic [CW-1:0] RDS_AT   = CW'(T_RDS);
   localparam logic [CW-1:0] LOW0_LEN = CW'(T_LOW0);
   localparam logic [CW-1:0] LOW1_LEN = CW'(T_LOW1);

   if (!(T_LOW1 < T_RDS && T_RDS < T_LOW0 && T_LOW0 < T_SLOT && T_MSP < T_RSTH))
   begin : g_bad_timing
      $error("onewire_seq: illegal timing parameters");
   end

   logic [2:0]    state;
   logic [1:0]    op_q;
   logic [7:0]    data_q;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          presence;
   logic          line;
   logic [CW-1:0] low_time;
   logic          accept;

   onewire_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus_in),
      .q     (line)
   );

   assign busy   = ~cmd_ready;
   assign accept = (state == ST_IDLE) && cmd_valid && cmd_ready;

   always_comb begin
      // NOTE: assign a default before any condition so no latch is inferred.
      low_time = LOW1_LEN;
      if (op_q == OP_WRITE && !data_q[idx]) low_time = LOW0_LEN;
   end

   // Outputs are registered from the current state, so they lag the state by one edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         op_q         <= OP_RESET;
         data_q       <= '0;
         cnt          <= '0;
         idx          <= '0;
         shreg        <= '0;
         presence     <= 1'b0;
         cmd_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_presence <= 1'b0;
         bus_oe       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values.
         rsp_valid <= 1'b0;
         bus_oe    <= (state == ST_RST_LOW) || (state == ST_SLOT && cnt < low_time);
         cmd_ready <= (state == ST_IDLE) && !accept;

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q     <= cmd_op;
                  data_q   <= cmd_data;
                  idx      <= '0;
                  cnt      <= '0;
                  shreg    <= '0;
                  presence <= 1'b0;
                  case (cmd_op)
                     OP_RESET:          state <= ST_RST_LOW;
                     OP_WRITE, OP_READ: state <= ST_SLOT;
                     default:           state <= ST_DONE;
                  endcase
               end
            end

            ST_RST_LOW: begin
               if (cnt == RSTL_END) begin
                  cnt   <= '0;
                  state <= ST_RST_WAIT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_RST_WAIT: begin
               if (cnt == MSP_AT) presence <= ~line;
               if (cnt == RSTH_END) begin
                  cnt   <= '0;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_SLOT: begin
               if (op_q == OP_READ && cnt == RDS_AT) shreg[idx] <= line;
               if (cnt == SLOT_END) begin
                  cnt <= '0;
                  if (idx == 3'd7) state <= ST_DONE;
                  else             idx   <= idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_DONE: begin
               rsp_valid    <= 1'b1;
               rsp_data     <= (op_q == OP_READ) ? shreg : 8'h00;
               rsp_presence <= (op_q == OP_RESET) && presence;
               state        <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_onewire_seq.sv
// Self-checking bench for onewire_seq: a command-level model predicts every output
// each cycle, a behavioural slave drives the line, and directed cases pin the model.
module tb_onewire_seq;
   import onewire_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready, rsp_valid, rsp_presence, busy, bus_oe;
   logic [7:0] rsp_data;
   wire        bus_in;

   int checks = 0;
   int errors = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   onewire_seq dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_data     (cmd_data),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_presence (rsp_presence),
      .busy         (busy),
      .bus_oe       (bus_oe),
      .bus_in       (bus_in)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- slave / line model ----------------
   logic       slave_present = 1'b0;
   logic       slave_reading = 1'b0;
   logic [7:0] slave_byte = 8'h00;
   logic       oe_prev = 1'b0;
   int         low_len = 0;
   int         rd_hold = 0;
   int         rd_bit = 0;
   int         rel_cnt = -1;
   int         widths[$];
   int         vcount = 0;
   logic       slave_pull;

   assign slave_pull = (rd_hold > 0) || (rel_cnt >= 15 && rel_cnt < 120);
   assign bus_in     = ~(bus_oe | slave_pull);

   always @(negedge clk) begin
      oe_prev <= bus_oe;
      if (bus_oe) begin
         low_len <= (oe_prev ? low_len : 0) + 1;
         rel_cnt <= -1;
      end else begin
         if (oe_prev) widths.push_back(low_len);
         if (oe_prev && low_len >= 400 && slave_present) rel_cnt <= 1;
         else if (rel_cnt >= 1 && rel_cnt < 200)         rel_cnt <= rel_cnt + 1;
         else                                            rel_cnt <= -1;
      end
      if (!slave_reading) rd_bit <= 0;
      if (bus_oe && !oe_prev && slave_reading) begin
         rd_hold <= slave_byte[rd_bit] ? 0 : 29;
         rd_bit  <= (rd_bit + 1) % 8;
      end else if (rd_hold > 0) begin
         rd_hold <= rd_hold - 1;
      end
      if (rsp_valid === 1'b1) vcount <= vcount + 1;
   end

   // ---------------- command-level model ----------------
   function automatic int lat_of(input logic [1:0] op);
      case (op)
         OP_RESET:          return 480 + 480 + 1;
         OP_WRITE, OP_READ: return 8 * 70 + 1;
         default:           return 1;
      endcase
   endfunction

   function automatic logic oe_of(input logic [1:0] op, input logic [7:0] d, input int t);
      int k, r;
      case (op)
         OP_RESET: return (t >= 1 && t <= 480);
         OP_WRITE, OP_READ: begin
            if (t < 1 || t > 8 * 70) return 1'b0;
            k = (t - 1) / 70;
            r = (t - 1) % 70;
            if (op == OP_WRITE && !d[k]) return (r < 60);
            return (r < 6);
         end
         default: return 1'b0;
      endcase
   endfunction

   int         edge_n = 0;
   logic       m_active = 1'b0, m_ready = 1'b1, m_rsp_pres = 1'b0;
   int         m_acc = 0;
   logic [1:0] m_op = 2'b00;
   logic [7:0] m_data = 8'h00, m_rsp_data = 8'h00;
   logic       n_active, n_ready, n_rsp_pres;
   int         n_acc;
   logic [1:0] n_op;
   logic [7:0] n_data, n_rsp_data;

   always_comb begin
      n_active = m_active; n_ready = m_ready; n_acc = m_acc; n_op = m_op; n_data = m_data;
      n_rsp_data = m_rsp_data; n_rsp_pres = m_rsp_pres;
      if (reset) begin
         n_active = 1'b0; n_ready = 1'b1; n_rsp_data = 8'h00; n_rsp_pres = 1'b0;
      end else begin
         if (m_active && edge_n - m_acc == lat_of(m_op)) begin
            n_rsp_data = (m_op == OP_READ) ? slave_byte : 8'h00;
            n_rsp_pres = (m_op == OP_RESET) && slave_present;
         end
         if (m_active && edge_n - m_acc == lat_of(m_op) + 1) n_active = 1'b0;
         if (m_ready && cmd_valid) begin
            n_active = 1'b1; n_ready = 1'b0; n_acc = edge_n; n_op = cmd_op; n_data = cmd_data;
         end else begin
            n_ready = !n_active;
         end
      end
   end

   always @(posedge clk) begin
      m_active <= n_active; m_ready <= n_ready; m_acc <= n_acc; m_op <= n_op;
      m_data <= n_data; m_rsp_data <= n_rsp_data; m_rsp_pres <= n_rsp_pres;
      edge_n <= edge_n + 1;
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmd_ready", cmd_ready, m_ready);
         check("busy", busy, !m_ready);
         check("bus_oe", bus_oe, m_active && oe_of(m_op, m_data, edge_n - 1 - m_acc));
         check("rsp_valid", rsp_valid, m_active && (edge_n - 1 - m_acc == lat_of(m_op)));
         check("rsp_data", rsp_data, m_rsp_data);
         check("rsp_presence", rsp_presence, m_rsp_pres);
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [1:0] op, input logic [7:0] d);
      int n = 0;
      while (!m_ready && n < 2000) begin @(negedge clk); n++; end
      check("send_ready_timeout", n < 2000, 1);
      cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int t);
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 1500) begin @(negedge clk); n++; end
      check("rsp_timeout", n < 1500, 1);
      t = edge_n - 1 - m_acc;
   endtask

   initial begin
      int t, a1, n, v0;
      int exp_w[8] = '{6, 60, 6, 60, 60, 6, 60, 6};

      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_presence", rsp_presence, 0);
      check("rst_bus_oe", bus_oe, 0);
      reset = 1'b0;
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);

      // RESET with a slave answering presence
      slave_present = 1'b1; widths.delete();
      send(OP_RESET, 8'h00);
      wait_rsp(t);
      check("reset_latency", t, 961);
      check("reset_presence", rsp_presence, 1);
      check("reset_pulse_count", widths.size(), 1);
      if (widths.size() > 0) check("reset_pulse_width", widths[0], 480);

      // RESET with no slave
      slave_present = 1'b0;
      send(OP_RESET, 8'h00);
      wait_rsp(t);
      check("noslave_latency", t, 961);
      check("noslave_presence", rsp_presence, 0);

      // WRITE_BYTE 0xA5
      widths.delete();
      send(OP_WRITE, 8'hA5);
      wait_rsp(t);
      check("write_latency", t, 561);
      check("write_rsp_data", rsp_data, 0);
      check("write_slot_count", widths.size(), 8);
      for (int i = 0; i < 8 && i < widths.size(); i++) check("write_low_width", widths[i], exp_w[i]);

      // READ_BYTE, slave returns 0x3C
      slave_byte = 8'h3C; slave_reading = 1'b1; widths.delete();
      send(OP_READ, 8'h00);
      wait_rsp(t);
      check("read_latency", t, 561);
      check("read_rsp_data", rsp_data, 8'h3C);
      check("read_slot_count", widths.size(), 8);
      for (int i = 0; i < 8 && i < widths.size(); i++) check("read_low_width", widths[i], 6);
      slave_reading = 1'b0;

      // Handshake: cmd_valid held with a second command queued behind the first
      @(negedge clk);
      n = 0;
      while (!m_ready && n < 100) begin @(negedge clk); n++; end
      cmd_op = OP_WRITE; cmd_data = 8'h0F; cmd_valid = 1'b1;
      @(negedge clk);
      a1 = m_acc;
      cmd_op = OP_READ; cmd_data = 8'h00;
      wait_rsp(t);
      check("hs_first_latency", t, 561);
      slave_byte = 8'h96; slave_reading = 1'b1;
      n = 0;
      while (m_acc == a1 && n < 20) begin @(negedge clk); n++; end
      cmd_valid = 1'b0;
      check("hs_second_accept", m_acc - a1, 563);
      repeat (100) @(negedge clk);
      cmd_op = OP_RSVD; cmd_valid = 1'b1;
      repeat (3) @(negedge clk);
      cmd_valid = 1'b0;
      wait_rsp(t);
      check("hs_second_latency", t, 561);
      check("hs_second_data", rsp_data, 8'h96);
      slave_reading = 1'b0;

      // Reserved op
      widths.delete();
      send(OP_RSVD, 8'hFF);
      wait_rsp(t);
      check("rsvd_latency", t, 1);
      check("rsvd_rsp_data", rsp_data, 0);
      check("rsvd_presence", rsp_presence, 0);
      repeat (5) @(negedge clk);
      check("rsvd_no_bus_oe", widths.size(), 0);

      // Reset mid-slot during a WRITE
      send(OP_WRITE, 8'h00);
      repeat (99) @(negedge clk);
      check("midrst_oe_before", bus_oe, 1);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_bus_oe", bus_oe, 0);
      check("midrst_cmd_ready", cmd_ready, 1);
      reset = 1'b0;
      v0 = vcount;
      repeat (700) @(negedge clk);
      check("midrst_no_rsp", vcount - v0, 0);
      slave_present = 1'b1;
      send(OP_RESET, 8'h00);
      wait_rsp(t);
      check("midrst_reset_latency", t, 961);
      check("midrst_reset_presence", rsp_presence, 1);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
